uart_rx_byte: RTL and testbench

- 8N1 UART receiver. Converts the board-level uart_rxd pin into parallel bytes with a valid/ready handshake.
- Lets user logic consume host traffic instead of looping it back to uart_txd.
- Sits between the uart_rxd top-level input and fabric logic (command decoder, LED control) on the SmartFusion2 Security Evaluation Kit designs.
- Single 50 MHz clock domain. uart_rxd is asynchronous to it.

---
 rtl/uart_rx_byte_if.sv | 27 ++
 rtl/uart_rx_byte.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Byte-level handshake between the UART receiver and the fabric logic
// that consumes host traffic (command decoder, LED control, ...).
// The receiver side is the master: it presents bytes and status pulses,
// the consumer answers with rx_ready.
interface uart_rx_byte_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: turns the asynchronous uart_rxd pin into parallel
// bytes with a valid/ready handshake. The bit timer is re-aligned on every
// start edge and samples at the middle of each bit. A stop bit sampled low
// raises one frame-error pulse and the receiver then waits for the line to
// return high, so a held-low break produces exactly one error.
module uart_rx_byte #(
  parameter real CLK_FREQUENCY = 50.0e6,
  parameter real BAUD_RATE     = 115200.0
) (
  input  logic          clk_50mhz,
  input  logic          rst_n,
  input  logic          uart_rxd,
  uart_rx_byte_if.master rx
);

  localparam int CLKS_PER_BIT = int'(CLK_FREQUENCY / BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts of the bit timer: mid start bit, then one full bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Too few clocks per bit leaves no room to find the bit centre.
  generate
    if (CLKS_PER_BIT < 4) begin : g_rate_check
      $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser on the raw pin (both stages reset to line-idle high).
  logic rxd_meta_q;
  logic rxd_s_q;

  // Frame-timing state.
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;

  // Output registers.
  logic [7:0] rx_data_q,      rx_data_d;
  logic       rx_valid_q,     rx_valid_d;
  logic       frame_err_q,    frame_err_d;
  logic       overrun_q,      overrun_d;

  logic accept;
  assign accept = rx_valid_q & rx.rx_ready;

  // Two-flop synchroniser bringing uart_rxd into the clk_50mhz domain.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Next-state logic: frame sequencing, bit sampling and output handshake.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // A consumed byte drops valid; a load later in this block wins.
    if (accept) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          // Still low at mid start bit: a genuine start, otherwise a glitch.
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rxd_s_q) begin
            // Good stop bit: present the byte and go back to hunting for
            // the next start edge without waiting for the stop bit to end.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx.rx_ready;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        clk_cnt_d = '0;
        if (rxd_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx.rx_data      = rx_data_q;
  assign rx.rx_valid     = rx_valid_q;
  assign rx.rx_frame_err = frame_err_q;
  assign rx.rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit. A monitor logs
// accepted bytes and counts status pulses; the stimulus sequence checks
// those logs against hand-computed expectations.
module tb_uart_rx_byte;
  localparam real CLK_F = 50.0e6;
  localparam real BAUD  = 6.25e6;
  localparam int  CPB   = 8;

  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_rx_byte_if rx_if ();

  uart_rx_byte #(
    .CLK_FREQUENCY (CLK_F),
    .BAUD_RATE     (BAUD)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .rx        (rx_if)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process).
  int         cyc       = 0;
  logic [7:0] rx_log [0:63];
  int         rx_cnt    = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         vrise_cnt = 0;
  int         vrise_cyc = 0;
  logic       valid_prev = 1'b0;

  // Sample DUT outputs 1 time unit after each rising edge.
  always @(posedge clk_50mhz) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (rx_if.rx_valid && !valid_prev) begin
        vrise_cnt++;
        vrise_cyc = cyc;
      end
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (rx_cnt < 64) rx_log[rx_cnt] = rx_if.rx_data;
        rx_cnt++;
      end
      if (rx_if.rx_frame_err) ferr_cnt++;
      if (rx_if.rx_overrun)   ovr_cnt++;
    end
    valid_prev = rx_if.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=0x%0h", tag, got);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clk_50mhz);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  initial begin
    int n0, fe0, ov0, vr0, t0, lat;
    logic [7:0] c3;

    rx_if.rx_ready = 1'b1;
    repeat (3) @(negedge clk_50mhz);

    // Reset state
    check("rst_valid", rx_if.rx_valid, 1'b0);
    check("rst_data",  rx_if.rx_data, 8'h00);
    check("rst_ferr",  rx_if.rx_frame_err, 1'b0);
    check("rst_ovr",   rx_if.rx_overrun, 1'b0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_50mhz);

    // 1. Single byte 0xA5 with latency from the pin falling edge
    n0 = rx_cnt; fe0 = ferr_cnt; ov0 = ovr_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk_50mhz);
    lat = vrise_cyc - t0;
    $display("info latency=%0d clocks (expected 78 +/- 1)", lat);
    check("t1_count", rx_cnt - n0, 1);
    check("t1_data",  rx_log[n0], 8'hA5);
    check("t1_lat_in_range", (lat >= 77 && lat <= 79), 1'b1);
    check("t1_ferr",  ferr_cnt - fe0, 0);
    check("t1_ovr",   ovr_cnt - ov0, 0);

    // 2. Back-to-back 0x00, 0xFF, 0x55
    n0 = rx_cnt; fe0 = ferr_cnt; ov0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk_50mhz);
    check("t2_count", rx_cnt - n0, 3);
    check("t2_byte0", rx_log[n0],     8'h00);
    check("t2_byte1", rx_log[n0 + 1], 8'hFF);
    check("t2_byte2", rx_log[n0 + 2], 8'h55);
    check("t2_ferr",  ferr_cnt - fe0, 0);
    check("t2_ovr",   ovr_cnt - ov0, 0);

    // 3. Backpressure: second byte overwrites the first
    n0 = rx_cnt; ov0 = ovr_cnt;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (2 * CPB) @(negedge clk_50mhz);
    check("t3_valid_held", rx_if.rx_valid, 1'b1);
    check("t3_data",       rx_if.rx_data, 8'h34);
    check("t3_ovr",        ovr_cnt - ov0, 1);
    check("t3_no_accept",  rx_cnt - n0, 0);
    rx_if.rx_ready = 1'b1;
    @(posedge clk_50mhz);
    #1;
    check("t3_valid_clear", rx_if.rx_valid, 1'b0);
    @(negedge clk_50mhz);

    // 4. Framing error on 0x3C, then 0x81 received normally
    n0 = rx_cnt; fe0 = ferr_cnt; vr0 = vrise_cnt;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    check("t4_ferr",     ferr_cnt - fe0, 1);
    check("t4_no_valid", vrise_cnt - vr0, 0);
    check("t4_data_kept", rx_if.rx_data, 8'h34);
    send_frame(8'h81, 1'b1);
    repeat (2) @(negedge clk_50mhz);
    check("t4_count", rx_cnt - n0, 1);
    check("t4_data",  rx_log[n0], 8'h81);

    // 5. Short glitch, then a 40-bit break
    fe0 = ferr_cnt; vr0 = vrise_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk_50mhz);
    check("t5_glitch_ferr",  ferr_cnt - fe0, 0);
    check("t5_glitch_valid", vrise_cnt - vr0, 0);
    uart_rxd = 1'b0;
    repeat (40 * CPB) @(negedge clk_50mhz);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk_50mhz);
    check("t5_break_ferr",  ferr_cnt - fe0, 1);
    check("t5_break_valid", vrise_cnt - vr0, 0);

    // 6. Reset in the middle of 0xC3 with a pending byte
    rx_if.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk_50mhz);
    check("t6_pending_valid", rx_if.rx_valid, 1'b1);
    check("t6_pending_data",  rx_if.rx_data, 8'h5A);
    c3 = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    uart_rxd = c3[4];
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rx_if.rx_valid, 1'b0);
    check("t6_rst_data",  rx_if.rx_data, 8'h00);
    check("t6_rst_ferr",  rx_if.rx_frame_err, 1'b0);
    repeat (4) @(negedge clk_50mhz);
    uart_rxd = 1'b1;
    rx_if.rx_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk_50mhz);
    n0 = rx_cnt; fe0 = ferr_cnt;
    send_frame(8'h7E, 1'b1);
    repeat (2) @(negedge clk_50mhz);
    check("t6_count", rx_cnt - n0, 1);
    check("t6_data",  rx_log[n0], 8'h7E);
    check("t6_ferr",  ferr_cnt - fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
